// File: rtl/matrix_stream_loader.sv
// Serial-to-parallel loader: collects two m x m matrices (A then B) from a
// stb/ack word stream and presents them with independent stb/ack handshakes.
module matrix_stream_loader #(
  parameter int m = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               in_data,
  input  logic                      in_stb,
  output logic                      in_ack,
  output logic [m-1:0][m-1:0][31:0] matrix_a,
  output logic                      matrix_a_stb,
  input  logic                      matrix_a_ack,
  output logic [m-1:0][m-1:0][31:0] matrix_b,
  output logic                      matrix_b_stb,
  input  logic                      matrix_b_ack
);

  localparam int unsigned MM = m * m;
  localparam int KW = (MM > 1) ? $clog2(MM) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(MM - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    PRESENT
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [KW-1:0] k;
  logic [KW-1:0] k_next;
  logic          a_stb_next;
  logic          b_stb_next;
  logic          ack_next;
  logic          xfer;
  logic          last;

  assign xfer = in_stb && in_ack;
  assign last = (k == K_LAST);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_next = state;
    k_next     = k;
    a_stb_next = matrix_a_stb & ~matrix_a_ack;
    b_stb_next = matrix_b_stb & ~matrix_b_ack;
    case (state)
      IDLE: state_next = LOAD_A;
      LOAD_A: begin
        if (xfer) begin
          if (last) begin
            k_next     = '0;
            state_next = LOAD_B;
          end else begin
            k_next = k + 1'b1;
          end
        end
      end
      LOAD_B: begin
        if (xfer) begin
          if (last) begin
            k_next     = '0;
            state_next = PRESENT;
            a_stb_next = 1'b1;
            b_stb_next = 1'b1;
          end else begin
            k_next = k + 1'b1;
          end
        end
      end
      PRESENT: begin
        // Return to loading on the same edge that retires the last pending stb.
        if (!a_stb_next && !b_stb_next) state_next = LOAD_A;
      end
      default: state_next = IDLE;
    endcase
    // in_ack is registered from the next state so it is glitch-free and
    // never depends combinationally on in_stb.
    ack_next = (state_next == LOAD_A) || (state_next == LOAD_B);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      k            <= '0;
      in_ack       <= 1'b0;
      matrix_a_stb <= 1'b0;
      matrix_b_stb <= 1'b0;
    end else begin
      state        <= state_next;
      k            <= k_next;
      in_ack       <= ack_next;
      matrix_a_stb <= a_stb_next;
      matrix_b_stb <= b_stb_next;
    end
  end

  // NOTE: the operand arrays are reset because the consumer may observe them
  // after a mid-load reset; a RAM-style store without reset would not allow that.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      matrix_a <= '0;
      matrix_b <= '0;
    end else if (xfer) begin
      for (int r = 0; r < m; r++) begin
        for (int c = 0; c < m; c++) begin
          if (k == KW'(r * m + c)) begin
            if (state == LOAD_A) matrix_a[r][c] <= in_data;
            if (state == LOAD_B) matrix_b[r][c] <= in_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed/randomized bench for matrix_stream_loader: a word-queue model
// predicts the row-major A/B contents and the handshake timing.
module tb_matrix_stream_loader;

  localparam int M  = 4;
  localparam int MM = M * M;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [31:0]               in_data;
  logic                      in_stb;
  logic                      in_ack;
  logic [M-1:0][M-1:0][31:0] matrix_a;
  logic                      matrix_a_stb;
  logic                      matrix_a_ack;
  logic [M-1:0][M-1:0][31:0] matrix_b;
  logic                      matrix_b_stb;
  logic                      matrix_b_ack;

  logic [31:0]               s_in_data;
  logic                      s_in_stb;
  logic                      s_in_ack;
  logic [0:0][0:0][31:0]     s_matrix_a;
  logic                      s_matrix_a_stb;
  logic                      s_matrix_a_ack;
  logic [0:0][0:0][31:0]     s_matrix_b;
  logic                      s_matrix_b_stb;
  logic                      s_matrix_b_ack;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] words[$];

  matrix_stream_loader #(.m(M)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_stb(in_stb), .in_ack(in_ack),
    .matrix_a(matrix_a), .matrix_a_stb(matrix_a_stb), .matrix_a_ack(matrix_a_ack),
    .matrix_b(matrix_b), .matrix_b_stb(matrix_b_stb), .matrix_b_ack(matrix_b_ack)
  );

  matrix_stream_loader #(.m(1)) dut_m1 (
    .clk(clk), .rst(rst),
    .in_data(s_in_data), .in_stb(s_in_stb), .in_ack(s_in_ack),
    .matrix_a(s_matrix_a), .matrix_a_stb(s_matrix_a_stb), .matrix_a_ack(s_matrix_a_ack),
    .matrix_b(s_matrix_b), .matrix_b_stb(s_matrix_b_stb), .matrix_b_ack(s_matrix_b_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Row-major rule: word n of the pair goes to A (n < MM) or B, at [n/M][n%M].
  task automatic check_mats();
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < M; c++) begin
        check($sformatf("A[%0d][%0d]", r, c), matrix_a[r][c], words[r*M+c]);
        check($sformatf("B[%0d][%0d]", r, c), matrix_b[r][c], words[MM+r*M+c]);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < M; c++) begin
        check($sformatf("%s_A[%0d][%0d]", tag, r, c), matrix_a[r][c], 32'h0);
        check($sformatf("%s_B[%0d][%0d]", tag, r, c), matrix_b[r][c], 32'h0);
      end
    end
  endtask

  // mode 0: in_stb held high, data 1,2,3...; mode 1: random gaps and data;
  // mode 2: in_stb toggling 1,0,1,0 with constant 1.0f.
  task automatic load(input int mode, input int nwords, input bit ack_noise);
    int          n;
    int          cyc;
    logic [31:0] w;
    n   = 0;
    cyc = 0;
    words.delete();
    while (n < nwords && cyc < 1000) begin
      case (mode)
        0:       begin in_stb = 1'b1; w = 32'(n + 1); end
        1:       begin in_stb = 1'($urandom_range(0, 1)); w = $urandom; end
        default: begin in_stb = (cyc % 2 == 0); w = 32'h3F80_0000; end
      endcase
      in_data = w;
      if (ack_noise) begin
        matrix_a_ack = 1'($urandom_range(0, 1));
        matrix_b_ack = 1'($urandom_range(0, 1));
      end
      check("in_ack_load", in_ack, 1);
      check("a_stb_load", matrix_a_stb, 0);
      check("b_stb_load", matrix_b_stb, 0);
      if (in_stb) begin
        words.push_back(w);
        n++;
      end
      step();
      cyc++;
    end
    in_stb       = 1'b0;
    in_data      = 32'h0;
    matrix_a_ack = 1'b0;
    matrix_b_ack = 1'b0;
  endtask

  initial begin
    rst            = 1'b0;
    in_data        = 32'h0;
    in_stb         = 1'b0;
    matrix_a_ack   = 1'b0;
    matrix_b_ack   = 1'b0;
    s_in_data      = 32'h0;
    s_in_stb       = 1'b0;
    s_matrix_a_ack = 1'b0;
    s_matrix_b_ack = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_in_ack", in_ack, 0);
    check("rst_a_stb", matrix_a_stb, 0);
    check("rst_b_stb", matrix_b_stb, 0);
    check("rst_m1_in_ack", s_in_ack, 0);
    check_zero("rst");

    // in_ack rises one cycle after reset release
    rst = 1'b1;
    check("in_ack_at_release", in_ack, 0);
    step();
    check("in_ack_after_release", in_ack, 1);
    check("m1_in_ack_after_release", s_in_ack, 1);

    // Continuous stream 1..32, both acks in first PRESENT cycle
    load(0, 2 * MM, 1'b0);
    check("t1_a_stb", matrix_a_stb, 1);
    check("t1_b_stb", matrix_b_stb, 1);
    check("t1_in_ack", in_ack, 0);
    check_mats();
    check("t1_A00", matrix_a[0][0], 32'd1);
    check("t1_A03", matrix_a[0][3], 32'd4);
    check("t1_A33", matrix_a[3][3], 32'd16);
    check("t1_B00", matrix_b[0][0], 32'd17);
    check("t1_B33", matrix_b[3][3], 32'd32);
    matrix_a_ack = 1'b1;
    matrix_b_ack = 1'b1;
    step();
    matrix_a_ack = 1'b0;
    matrix_b_ack = 1'b0;
    check("t1_a_stb_one_cycle", matrix_a_stb, 0);
    check("t1_b_stb_one_cycle", matrix_b_stb, 0);
    check("t1_in_ack_again", in_ack, 1);

    // Gapped stream: PRESENT only after the 32nd accepted word
    load(2, 2 * MM, 1'b0);
    check("t2_a_stb", matrix_a_stb, 1);
    check("t2_b_stb", matrix_b_stb, 1);
    check("t2_in_ack", in_ack, 0);
    check_mats();

    // Staggered acks: A at PRESENT cycle 2, B at cycle 5
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("t3_a_stb_c%0d", c), matrix_a_stb, 32'(c <= 2));
      check($sformatf("t3_b_stb_c%0d", c), matrix_b_stb, 32'(c <= 5));
      check($sformatf("t3_in_ack_c%0d", c), in_ack, 32'(c >= 6));
      if (c == 4) check_mats();
      matrix_a_ack = (c == 2);
      matrix_b_ack = (c == 5);
      step();
    end
    matrix_a_ack = 1'b0;
    matrix_b_ack = 1'b0;

    // Random data with acks toggling during load: they must be ignored
    load(1, 2 * MM, 1'b1);
    repeat (3) begin
      check("t4_a_stb_wait", matrix_a_stb, 1);
      check("t4_b_stb_wait", matrix_b_stb, 1);
      check("t4_in_ack_wait", in_ack, 0);
      step();
    end
    check_mats();
    matrix_b_ack = 1'b1;
    step();
    matrix_b_ack = 1'b0;
    check("t4_a_stb_held", matrix_a_stb, 1);
    check("t4_b_stb_clr", matrix_b_stb, 0);
    check("t4_in_ack_held", in_ack, 0);
    matrix_a_ack = 1'b1;
    step();
    matrix_a_ack = 1'b0;
    check("t4_a_stb_clr", matrix_a_stb, 0);
    check("t4_in_ack_back", in_ack, 1);

    // Reset after 10 words of A
    load(1, 10, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("t5_in_ack", in_ack, 0);
    check("t5_a_stb", matrix_a_stb, 0);
    check("t5_b_stb", matrix_b_stb, 0);
    check_zero("t5");
    step();
    rst = 1'b1;
    step();
    check("t5_in_ack_release", in_ack, 1);
    load(1, 2 * MM, 1'b0);
    check("t5_a_stb_full", matrix_a_stb, 1);
    check("t5_b_stb_full", matrix_b_stb, 1);
    check_mats();
    matrix_a_ack = 1'b1;
    matrix_b_ack = 1'b1;
    step();
    matrix_a_ack = 1'b0;
    matrix_b_ack = 1'b0;
    check("t5_in_ack_after", in_ack, 1);

    // m = 1 instance
    check("t6_in_ack", s_in_ack, 1);
    s_in_stb  = 1'b1;
    s_in_data = 32'hDEAD_BEEF;
    step();
    check("t6_a_stb_mid", s_matrix_a_stb, 0);
    check("t6_b_stb_mid", s_matrix_b_stb, 0);
    check("t6_in_ack_mid", s_in_ack, 1);
    s_in_data = 32'h1234_5678;
    step();
    s_in_stb  = 1'b0;
    s_in_data = 32'h0;
    check("t6_a_stb", s_matrix_a_stb, 1);
    check("t6_b_stb", s_matrix_b_stb, 1);
    check("t6_in_ack_present", s_in_ack, 0);
    check("t6_A00", s_matrix_a[0][0], 32'hDEAD_BEEF);
    check("t6_B00", s_matrix_b[0][0], 32'h1234_5678);
    s_matrix_a_ack = 1'b1;
    s_matrix_b_ack = 1'b1;
    step();
    s_matrix_a_ack = 1'b0;
    s_matrix_b_ack = 1'b0;
    check("t6_a_stb_clr", s_matrix_a_stb, 0);
    check("t6_in_ack_again", s_in_ack, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
